// File: rtl/snac_db15_reader.sv
// rtl/snac_db15_reader.sv - DB15 SNAC serial joystick reader (74HC165 chain, 24 bits/frame).
// Optional two-frame debounce of the button words: define SNAC_DEBOUNCE_EN.
module snac_db15_reader #(
   parameter int CLK_DIV   = 48,
   parameter int GAP_TICKS = 1000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        JOY_DATA,
   output logic        JOY_CLK,
   output logic        JOY_LOAD,
   output logic [11:0] joystick1,
   output logic [11:0] joystick2,
   output logic        present,
   output logic        frame_done
);

   localparam int TW = $clog2(CLK_DIV);
   localparam int GW = $clog2(GAP_TICKS + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SETTLE,
      S_SHIFT_LO,
      S_SHIFT_HI,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [TW-1:0] tick_q, tick_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [4:0]  bit_q, bit_d;
   logic [23:0] raw_q, raw_d;
   logic        sync1_q, sync2_q;
   logic        joy_clk_q, joy_clk_d;
   logic        joy_load_q, joy_load_d;
   logic [11:0] joy1_q, joy1_d;
   logic [11:0] joy2_q, joy2_d;
   logic        present_q, present_d;
   logic        frame_done_q, frame_done_d;
   logic        tick;
`ifdef SNAC_DEBOUNCE_EN
   logic [23:0] prev_q, prev_d;
`endif

   assign tick = (tick_q == TW'(CLK_DIV - 1));

   always_comb begin
      state_d      = state_q;
      tick_d       = tick_q;
      gap_d        = gap_q;
      bit_d        = bit_q;
      raw_d        = raw_q;
      joy1_d       = joy1_q;
      joy2_d       = joy2_q;
      present_d    = present_q;
      frame_done_d = 1'b0;
`ifdef SNAC_DEBOUNCE_EN
      prev_d       = prev_q;
`endif

      // Holding the divider during the one-cycle DONE state keeps every IDLE tick a full CLK_DIV long.
      if (state_q != S_DONE) begin
         tick_d = tick ? '0 : tick_q + TW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (tick) begin
               if (gap_q == GW'(GAP_TICKS - 1)) begin
                  gap_d   = '0;
                  state_d = S_LOAD;
               end else begin
                  gap_d = gap_q + GW'(1);
               end
            end
         end
         S_LOAD:   if (tick) state_d = S_SETTLE;
         S_SETTLE: if (tick) state_d = S_SHIFT_LO;
         S_SHIFT_LO: begin
            if (tick) begin
               raw_d[bit_q] = ~sync2_q;
               state_d      = S_SHIFT_HI;
            end
         end
         S_SHIFT_HI: begin
            if (tick) begin
               if (bit_q == 5'd23) begin
                  bit_d   = '0;
                  state_d = S_DONE;
               end else begin
                  bit_d   = bit_q + 5'd1;
                  state_d = S_SHIFT_LO;
               end
            end
         end
         S_DONE: begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
            if (raw_q == 24'hFFFFFF) begin
               present_d = 1'b0;
               joy1_d    = '0;
               joy2_d    = '0;
            end else begin
               present_d = 1'b1;
`ifdef SNAC_DEBOUNCE_EN
               if (raw_q == prev_q) begin
                  joy1_d = raw_q[11:0];
                  joy2_d = raw_q[23:12];
               end
`else
               joy1_d = raw_q[11:0];
               joy2_d = raw_q[23:12];
`endif
            end
`ifdef SNAC_DEBOUNCE_EN
            prev_d = raw_q;
`endif
         end
         default: state_d = S_IDLE;
      endcase

      if (!enable) begin
         state_d      = S_IDLE;
         tick_d       = '0;
         gap_d        = '0;
         bit_d        = '0;
         raw_d        = '0;
         joy1_d       = '0;
         joy2_d       = '0;
         present_d    = 1'b0;
         frame_done_d = 1'b0;
`ifdef SNAC_DEBOUNCE_EN
         prev_d       = '0;
`endif
      end

      // Pin levels follow the next state so the flops line up exactly with state_q.
      joy_clk_d  = (state_d != S_SHIFT_LO);
      joy_load_d = (state_d != S_LOAD);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         tick_q       <= '0;
         gap_q        <= '0;
         bit_q        <= '0;
         raw_q        <= '0;
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         joy_clk_q    <= 1'b1;
         joy_load_q   <= 1'b1;
         joy1_q       <= '0;
         joy2_q       <= '0;
         present_q    <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef SNAC_DEBOUNCE_EN
         prev_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         tick_q       <= tick_d;
         gap_q        <= gap_d;
         bit_q        <= bit_d;
         raw_q        <= raw_d;
         sync1_q      <= JOY_DATA;
         sync2_q      <= sync1_q;
         joy_clk_q    <= joy_clk_d;
         joy_load_q   <= joy_load_d;
         joy1_q       <= joy1_d;
         joy2_q       <= joy2_d;
         present_q    <= present_d;
         frame_done_q <= frame_done_d;
`ifdef SNAC_DEBOUNCE_EN
         prev_q       <= prev_d;
`endif
      end
   end

   assign JOY_CLK    = joy_clk_q;
   assign JOY_LOAD   = joy_load_q;
   assign joystick1  = joy1_q;
   assign joystick2  = joy2_q;
   assign present    = present_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_snac_db15_reader.sv
// tb/tb_snac_db15_reader.sv - scoreboard bench for snac_db15_reader with a 74HC165 adapter model.
module tb_snac_db15_reader;
   localparam int CD        = 4;
   localparam int GAP       = 10;
   localparam int FRAME_CYC = (GAP + 50) * CD + 1;

   typedef struct packed {
      logic        p;
      logic [11:0] j1;
      logic [11:0] j2;
   } exp_t;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable  = 1'b0;
   logic        JOY_DATA;
   logic        JOY_CLK, JOY_LOAD, present, frame_done;
   logic [11:0] joystick1, joystick2;

   logic [23:0] next_pat = 24'hFFFFFF;
   logic [23:0] shreg    = 24'hFFFFFF;
   exp_t        sb[$];
   exp_t        m_out    = '0;
   logic [23:0] m_prev   = '0;
   int          n_cmp = 0, n_fail = 0;
   int          evt_cnt[3] = '{0, 0, 0};
   int          load_low = 0, clk_low = 0, clk_pulses = 0, gap_cyc = 0;
   bit          gap_armed = 0;
   logic        load_prev = 1'b1, clk_prev = 1'b1;
   logic [23:0] pat;

   assign JOY_DATA = shreg[0];

   snac_db15_reader #(.CLK_DIV(CD), .GAP_TICKS(GAP)) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .enable    (enable),
      .JOY_DATA  (JOY_DATA),
      .JOY_CLK   (JOY_CLK),
      .JOY_LOAD  (JOY_LOAD),
      .joystick1 (joystick1),
      .joystick2 (joystick2),
      .present   (present),
      .frame_done(frame_done)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: wire bits are active-low buttons, all-ones raw means the adapter is absent.
   task automatic model_push(input logic [23:0] w);
      logic [23:0] raw;
      raw = ~w;
      if (raw == 24'hFFFFFF) begin
         m_out = '0;
      end else begin
         m_out.p = 1'b1;
`ifdef SNAC_DEBOUNCE_EN
         if (raw == m_prev) begin
            m_out.j1 = raw[11:0];
            m_out.j2 = raw[23:12];
         end
`else
         m_out.j1 = raw[11:0];
         m_out.j2 = raw[23:12];
`endif
      end
      m_prev = raw;
      sb.push_back(m_out);
   endtask

   task automatic model_clear();
      sb.delete();
      m_prev = '0;
      m_out  = '0;
   endtask

   // Adapter model plus monitor: latch on load, shift on JOY_CLK rise, score on frame_done.
   always @(negedge clk_sys) begin
      exp_t e;
      gap_cyc++;
      if (JOY_LOAD === 1'b0 && load_prev === 1'b1) begin
         evt_cnt[1]++;
         clk_pulses = 0;
         shreg = next_pat;
         model_push(next_pat);
         if (gap_armed) begin
            check("gap_cycles", gap_cyc, GAP * CD);
            gap_armed = 0;
         end
      end
      if (JOY_LOAD === 1'b0) load_low++;
      else if (load_low != 0) begin
         check("load_width", load_low, CD);
         load_low = 0;
      end
      if (JOY_CLK === 1'b0) clk_low++;
      else if (clk_low != 0) begin
         check("clk_low_width", clk_low, CD);
         clk_low = 0;
      end
      if (JOY_CLK === 1'b1 && clk_prev === 1'b0) begin
         evt_cnt[2]++;
         clk_pulses++;
         shreg = {1'b1, shreg[23:1]};
      end
      if (frame_done === 1'b1) begin
         evt_cnt[0]++;
         check("clk_pulses", clk_pulses, 24);
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_frame_done: got frame_done=1 want no frame at %0t", $time);
         end else begin
            e = sb.pop_front();
            check("present", {31'd0, present}, {31'd0, e.p});
            check("joystick1", {20'd0, joystick1}, {20'd0, e.j1});
            check("joystick2", {20'd0, joystick2}, {20'd0, e.j2});
         end
         gap_armed = 1;
         gap_cyc   = 0;
      end
      load_prev = JOY_LOAD;
      clk_prev  = JOY_CLK;
   end

   task automatic wait_evt(input int which, input int n);
      int target;
      bit hit;
      target = evt_cnt[which] + n;
      hit    = 0;
      for (int i = 0; i < FRAME_CYC * 2 * n && !hit; i++) begin
         @(negedge clk_sys);
         #1;
         if (evt_cnt[which] >= target) hit = 1;
      end
      n_cmp++;
      if (!hit) begin
         n_fail++;
         $display("FAIL wait_evt%0d: got timeout want event", which);
      end
   endtask

   task automatic run_frame(input logic [23:0] p);
      next_pat = p;
      wait_evt(0, 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_joy_clk"}, {31'd0, JOY_CLK}, 32'd1);
      check({tag, "_joy_load"}, {31'd0, JOY_LOAD}, 32'd1);
      check({tag, "_joystick1"}, {20'd0, joystick1}, 32'd0);
      check({tag, "_joystick2"}, {20'd0, joystick2}, 32'd0);
      check({tag, "_present"}, {31'd0, present}, 32'd0);
      check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
   endtask

   initial begin
      enable = 1'b1;
      repeat (2) @(negedge clk_sys);
      check_idle_outputs("reset");
      #1 reset_n = 1'b1;
      gap_cyc   = 0;
      gap_armed = 1;

      wait_evt(0, 1);
      run_frame(~24'h00A005);
      run_frame(~24'h00A005);
      run_frame(24'h000000);
      run_frame(~24'h00A005);
      run_frame(~24'h00A005);

      pat = 24'($urandom);
      for (int i = 0; i < 8; i++) begin
         if ($urandom_range(0, 1) == 0) pat = 24'($urandom);
         run_frame(pat);
      end

      for (int i = 0; i < 4; i++) run_frame((i % 2 == 1) ? ~24'h000010 : 24'hFFFFFF);
      run_frame(~24'h000010);
      run_frame(~24'h000010);

      // Abort while shifting bit 10.
      next_pat = ~24'h3C5A96;
      wait_evt(1, 1);
      wait_evt(2, 11);
      @(negedge clk_sys);
      #1 enable = 1'b0;
      model_clear();
      @(negedge clk_sys);
      check_idle_outputs("abort");
      repeat (5) @(negedge clk_sys);
      #1 enable = 1'b1;
      gap_cyc   = 0;
      gap_armed = 1;
      wait_evt(0, 1);
      run_frame(~24'h3C5A96);

      // Asynchronous reset mid-shift.
      next_pat = ~24'h123456;
      wait_evt(1, 1);
      wait_evt(2, 5);
      #2 reset_n = 1'b0;
      model_clear();
      #1 check_idle_outputs("async_reset");
      repeat (3) @(negedge clk_sys);
      #1 reset_n = 1'b1;
      next_pat  = 24'hFFFFFF;
      gap_cyc   = 0;
      gap_armed = 1;
      wait_evt(0, 1);

      repeat (4) @(negedge clk_sys);
      check("sb_drain", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
